// File: rtl/traffic_phase_scheduler_if.sv
// ---------------------------------------------------------------------------
// traffic_phase_scheduler_if
//
// Bundles the time base, request/preemption inputs and the light/grant/status
// outputs of the traffic phase scheduler.
//
//   tick           controller -> scheduler  one-cycle time-base strobe
//   req            controller -> scheduler  per-approach request (N_APP)
//   preempt_valid  controller -> scheduler  emergency preemption request
//   preempt_id     controller -> scheduler  approach to preempt to
//   lights         scheduler -> controller  3 bits per approach (100/010/001)
//   grant          scheduler -> controller  one-hot green/yellow owner
//   pending        scheduler -> controller  latched requests
//   phase          scheduler -> controller  0 IDLE, 1 GREEN, 2 YELLOW, 3 ALLRED
//
// master: the side driving the inputs (controller / testbench)
// slave : the scheduler itself
// ---------------------------------------------------------------------------
interface traffic_phase_scheduler_if #(
  parameter int N_APP = 4
);
  localparam int IDW = $clog2(N_APP);

  logic                 tick;
  logic [N_APP-1:0]     req;
  logic                 preempt_valid;
  logic [IDW-1:0]       preempt_id;
  logic [3*N_APP-1:0]   lights;
  logic [N_APP-1:0]     grant;
  logic [N_APP-1:0]     pending;
  logic [1:0]           phase;

  modport master (
    output tick, req, preempt_valid, preempt_id,
    input  lights, grant, pending, phase
  );

  modport slave (
    input  tick, req, preempt_valid, preempt_id,
    output lights, grant, pending, phase
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// ---------------------------------------------------------------------------
// traffic_phase_scheduler
//
// Demand-driven round-robin phase scheduler for a multi-approach
// intersection. Requests are latched per approach; one approach at a time
// runs GREEN -> YELLOW -> ALLRED, with a minimum green time before it can be
// displaced and green resting indefinitely when nobody else is waiting.
//
// Ports:
//   clk   clock
//   rst   asynchronous, active-high reset
//   bus   traffic_phase_scheduler_if.slave
//           tick, req, preempt_valid, preempt_id  (inputs)
//           lights, grant, pending, phase         (outputs)
//
// Compile-time option:
//   TRAFFIC_SCHED_PREEMPT_EN  when defined, preempt_valid/preempt_id force
//                             the right-of-way to preempt_id; otherwise the
//                             preempt inputs are ignored.
// ---------------------------------------------------------------------------
module traffic_phase_scheduler #(
  parameter int N_APP       = 4,
  parameter int T_MIN_GREEN = 6,
  parameter int T_MAX_GREEN = 10,
  parameter int T_YELLOW    = 2,
  parameter int T_ALLRED    = 1,
  parameter int TW          = 4
) (
  input  logic clk,
  input  logic rst,
  traffic_phase_scheduler_if.slave bus
);

  localparam int IDW = $clog2(N_APP);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_ALLRED = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [TW-1:0]      timer_reg, timer_next;
  logic [IDW-1:0]     last_reg,  last_next;     // last winner == current owner
  logic [N_APP-1:0]   pending_reg, pending_next;

  logic [N_APP-1:0]   owner_mask;
  logic [N_APP-1:0]   eff_pend;
  logic               others_pend;
  logic               rr_found;
  logic [IDW-1:0]     rr_winner;
  logic [IDW-1:0]     rr_cand;
  logic               sel_ok;
  logic [IDW-1:0]     sel_id;
  logic               enter_green;
  logic [TW-1:0]      timer_inc;
  logic               pre_act;
  logic [N_APP-1:0]   pend_set, pend_clr;
  logic [N_APP-1:0]   grant_int;
  logic [3*N_APP-1:0] lights_int;

  // -------------------------------------------------------------------------
  // Preemption qualifier
  // -------------------------------------------------------------------------
`ifdef TRAFFIC_SCHED_PREEMPT_EN
  logic pre_id_ok;

  // An out-of-range id is ignored; only possible when N_APP is not a power
  // of two.
  always_comb begin
    pre_id_ok = 1'b0;
    for (int k = 0; k < N_APP; k++) begin
      if (bus.preempt_id == IDW'(k)) pre_id_ok = 1'b1;
    end
  end

  assign pre_act = bus.preempt_valid && pre_id_ok;
`else
  logic unused_preempt;

  assign unused_preempt = ^{bus.preempt_valid, bus.preempt_id};
  assign pre_act        = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Request view used for arbitration: requests arriving this very cycle are
  // included, so a req in the ALLRED exit cycle takes part in that decision.
  // -------------------------------------------------------------------------
  always_comb begin
    eff_pend    = pending_reg | bus.req;
    others_pend = |(eff_pend & ~owner_mask);
    rr_found    = 1'b0;
    rr_winner   = last_reg;
    rr_cand     = last_reg;
    for (int k = 1; k <= N_APP; k++) begin
      rr_cand = IDW'((int'(last_reg) + k) % N_APP);
      if (!rr_found && eff_pend[rr_cand]) begin
        rr_found  = 1'b1;
        rr_winner = rr_cand;
      end
    end
  end

  // Preemption target beats round-robin and never needs a pending bit.
  assign sel_ok = pre_act || rr_found;
  assign sel_id = pre_act ? bus.preempt_id : rr_winner;

  assign timer_inc = (timer_reg >= TW'(T_MAX_GREEN)) ? timer_reg
                                                     : timer_reg + TW'(1);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      timer_reg   <= '0;
      last_reg    <= IDW'(N_APP - 1);
      pending_reg <= '0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      last_reg    <= last_next;
      pending_reg <= pending_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg;
    last_next   = last_reg;
    enter_green = 1'b0;

    unique case (state_reg)
      S_IDLE: begin
        if (bus.tick && sel_ok) begin
          state_next  = S_GREEN;
          timer_next  = '0;
          last_next   = sel_id;
          enter_green = 1'b1;
        end
      end

      S_GREEN: begin
        if (pre_act && (bus.preempt_id != last_reg)) begin
          // Emergency for another approach: leave green immediately.
          state_next = S_YELLOW;
          timer_next = '0;
        end else if (bus.tick) begin
          // The count keeps running while a preemption holds this green, so
          // on release the minimum is already satisfied.
          if (!pre_act && others_pend && (timer_inc >= TW'(T_MIN_GREEN))) begin
            state_next = S_YELLOW;
            timer_next = '0;
          end else begin
            timer_next = timer_inc;
          end
        end
      end

      S_YELLOW: begin
        if (bus.tick) begin
          if (timer_reg == TW'(T_YELLOW - 1)) begin
            state_next = S_ALLRED;
            timer_next = '0;
          end else begin
            timer_next = timer_reg + TW'(1);
          end
        end
      end

      S_ALLRED: begin
        if (bus.tick) begin
          if (timer_reg == TW'(T_ALLRED - 1)) begin
            timer_next = '0;
            if (sel_ok) begin
              state_next  = S_GREEN;
              last_next   = sel_id;
              enter_green = 1'b1;
            end else begin
              state_next = S_IDLE;
            end
          end else begin
            timer_next = timer_reg + TW'(1);
          end
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Per-approach request latch and light decode
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < N_APP; gi++) begin : g_app
      assign owner_mask[gi] = (last_reg == IDW'(gi));

      // The green owner cannot re-request itself; entering green clears the
      // bit and wins over a simultaneous set.
      assign pend_set[gi]     = bus.req[gi] && !((state_reg == S_GREEN) && owner_mask[gi]);
      assign pend_clr[gi]     = enter_green && (last_next == IDW'(gi));
      assign pending_next[gi] = (pending_reg[gi] | pend_set[gi]) & ~pend_clr[gi];

      assign grant_int[gi] = owner_mask[gi] &&
                             ((state_reg == S_GREEN) || (state_reg == S_YELLOW));

      assign lights_int[3*gi +: 3] = !grant_int[gi]          ? 3'b100 :
                                     (state_reg == S_GREEN)  ? 3'b001 : 3'b010;
    end
  endgenerate

  assign bus.lights  = lights_int;
  assign bus.grant   = grant_int;
  assign bus.pending = pending_reg;
  assign bus.phase   = state_reg;

endmodule
